// File: rtl/fsk_rate_sel_n.sv
// ---------------------------------------------------------------------------
// fsk_rate_sel_n
//
// Purpose
//   Selects one of NCH tuning words (for example FSK tone / rate words for an
//   NCO) and presents it registered on Mout. Channel-change requests can
//   arrive at any time. They are applied only on a symbol boundary
//   (Sym_Tick), so a symbol is never split between two tuning words.
//   When the request is still pending the last request wins. Out-of-range
//   requests are dropped and flagged.
//
// Optional feature (macro FSK_RATE_SEL_DWELL_EN)
//   When defined, every real channel change is followed by a dwell period of
//   DWELL cycles. No further switch can happen during that period. Requests
//   made during the dwell are still captured. When the macro is undefined,
//   no dwell state or counter exists and DWELL is only range-checked.
//
// Parameters
//   WIDTH     width of each tuning word and of Mout
//   NCH       number of input channels (2..8)
//   SELW      selector width (2**SELW >= NCH)
//   DWELL     minimum cycles between switches (1..65535, dwell build only)
//   RESET_SEL channel applied out of reset (< NCH)
//
// Ports
//   Clock        in   single clock, all state on the rising edge
//   Reset_n      in   asynchronous active-low reset
//   Min          in   flattened tuning words, channel k at [k*WIDTH +: WIDTH]
//   Sel          in   requested channel
//   Sel_Valid    in   one-cycle strobe qualifying Sel
//   Sym_Tick     in   symbol-boundary strobe; switches happen only here
//   Mout         out  registered tuning word of the current channel
//   Cur_Sel      out  currently applied channel
//   Pending      out  a valid request is waiting for a symbol boundary
//   Switch_Pulse out  high for the first cycle a new channel is shown
//   Sel_Err      out  one-cycle pulse for a request with Sel >= NCH
//   dbg_state    out  FSM state (0 IDLE, 1 PEND, 2 DWELL) for checkers
//
// Request handshake: Sel is sampled on every rising edge where Sel_Valid is
// high. There is no back-pressure, so a request is never stalled. It is
// either taken into the pending slot or rejected through Sel_Err.
// ---------------------------------------------------------------------------
module fsk_rate_sel_n #(
    parameter int WIDTH     = 48,
    parameter int NCH       = 4,
    parameter int SELW      = 2,
    parameter int DWELL     = 16,
    parameter int RESET_SEL = 0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [NCH*WIDTH-1:0]  Min,
    input  logic [SELW-1:0]       Sel,
    input  logic                  Sel_Valid,
    input  logic                  Sym_Tick,
    output logic [WIDTH-1:0]      Mout,
    output logic [SELW-1:0]       Cur_Sel,
    output logic                  Pending,
    output logic                  Switch_Pulse,
    output logic                  Sel_Err,
    output logic [1:0]            dbg_state
);

    // Elaboration-time parameter sanity checks.
    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("fsk_rate_sel_n: NCH must be in 2..8");
    end
    if ((1 << SELW) < NCH) begin : g_bad_selw
        $error("fsk_rate_sel_n: SELW too narrow for NCH");
    end
    if (RESET_SEL < 0 || RESET_SEL >= NCH) begin : g_bad_rst_sel
        $error("fsk_rate_sel_n: RESET_SEL must be below NCH");
    end
    if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
        $error("fsk_rate_sel_n: DWELL must be in 1..65535");
    end

    localparam logic [SELW-1:0] RST_SEL = SELW'(RESET_SEL);
    // One extra bit so that NCH itself can be represented when NCH == 2**SELW.
    localparam logic [SELW:0]   NCH_LIM = (SELW+1)'(NCH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1
`ifdef FSK_RATE_SEL_DWELL_EN
        ,
        ST_DWELL = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   cur_sel_q, cur_sel_d;
    logic [SELW-1:0]   pend_sel_q, pend_sel_d;
    logic              pending_q, pending_d;
    logic              switch_pulse_q, switch_pulse_d;
    logic              sel_err_q, sel_err_d;
    logic [WIDTH-1:0]  mout_q, mout_d;
    logic              sel_ok;

`ifdef FSK_RATE_SEL_DWELL_EN
    localparam logic [15:0] DWELL_LOAD = 16'(DWELL - 1);
    logic [15:0]       cnt_q, cnt_d;
`endif

    assign sel_ok = Sel_Valid && ({1'b0, Sel} < NCH_LIM);

    always_comb begin
        state_d        = state_q;
        cur_sel_d      = cur_sel_q;
        pend_sel_d     = pend_sel_q;
        pending_d      = pending_q;
        switch_pulse_d = 1'b0;
        sel_err_d      = Sel_Valid && !sel_ok;
`ifdef FSK_RATE_SEL_DWELL_EN
        cnt_d          = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Sym_Tick has no effect here.
                if (sel_ok) begin
                    pend_sel_d = Sel;
                    pending_d  = 1'b1;
                    state_d    = ST_PEND;
                end
            end

            ST_PEND: begin
                if (Sym_Tick) begin
                    // The request that was already pending is applied. A
                    // request arriving in this same cycle becomes the next
                    // pending one.
                    cur_sel_d      = pend_sel_q;
                    pending_d      = 1'b0;
                    state_d        = ST_IDLE;
                    // Re-selecting the current channel is accepted silently.
                    switch_pulse_d = (pend_sel_q != cur_sel_q);
`ifdef FSK_RATE_SEL_DWELL_EN
                    if (pend_sel_q != cur_sel_q) begin
                        state_d = ST_DWELL;
                        cnt_d   = DWELL_LOAD;
                    end
`endif
                    if (sel_ok) begin
                        pend_sel_d = Sel;
                        pending_d  = 1'b1;
                        if (state_d == ST_IDLE) begin
                            state_d = ST_PEND;
                        end
                    end
                end else if (sel_ok) begin
                    pend_sel_d = Sel;
                end
            end

`ifdef FSK_RATE_SEL_DWELL_EN
            ST_DWELL: begin
                // Requests are captured but Sym_Tick is ignored, including in
                // the cycle that hands over to PEND.
                if (sel_ok) begin
                    pend_sel_d = Sel;
                    pending_d  = 1'b1;
                end
                if (cnt_q == 16'd0) begin
                    state_d = pending_d ? ST_PEND : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mout follows the channel that will be current after this edge, so
        // the new word appears in the same cycle as the new Cur_Sel.
        mout_d = Min[int'(cur_sel_d) * WIDTH +: WIDTH];
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= ST_IDLE;
            cur_sel_q      <= RST_SEL;
            pend_sel_q     <= RST_SEL;
            pending_q      <= 1'b0;
            switch_pulse_q <= 1'b0;
            sel_err_q      <= 1'b0;
            mout_q         <= '0;
`ifdef FSK_RATE_SEL_DWELL_EN
            cnt_q          <= 16'd0;
`endif
        end else begin
            state_q        <= state_d;
            cur_sel_q      <= cur_sel_d;
            pend_sel_q     <= pend_sel_d;
            pending_q      <= pending_d;
            switch_pulse_q <= switch_pulse_d;
            sel_err_q      <= sel_err_d;
            mout_q         <= mout_d;
`ifdef FSK_RATE_SEL_DWELL_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign Mout         = mout_q;
    assign Cur_Sel      = cur_sel_q;
    assign Pending      = pending_q;
    assign Switch_Pulse = switch_pulse_q;
    assign Sel_Err      = sel_err_q;
    assign dbg_state    = state_q;

endmodule
